// File: rtl/multi_click_decoder.sv
// multi_click_decoder: groups press pulses within a gap window into click events queued over valid/ready
module multi_click_decoder #(
  parameter int CLK_FREQUENCY = 10_000_000,
  parameter int WINDOW_HZ = 4,
  parameter int MAX_CLICKS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [3:0] event_count,
  output logic       dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [25:0] T_LAST = 26'(CLK_FREQUENCY / WINDOW_HZ - 1);
  localparam logic [3:0] MAX_C = 4'(MAX_CLICKS);
  typedef enum logic {IDLE, GATHER} state_t;
  state_t state;
  logic [3:0] cnt, nxt_cnt, push_val;
  logic [25:0] timer;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic push, pop, full;
  assign nxt_cnt = state == IDLE ? 4'd1 : cnt + 4'd1;
  always_comb begin
    push = press ? nxt_cnt == MAX_C : state == GATHER && timer == T_LAST;
    push_val = press ? nxt_cnt : cnt;
  end
  assign event_valid = wp != rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop = event_valid && event_ready;
  assign event_count = event_valid ? mem[rp[AW-1:0]] : 4'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      timer <= 26'd0;
      wp <= '0;
      rp <= '0;
      dropped <= 1'b0;
    end else begin
      if (press) begin
        cnt <= nxt_cnt;
        timer <= 26'd0;
        state <= push ? IDLE : GATHER;
      end else if (state == GATHER) begin
        if (push) state <= IDLE;
        else timer <= timer + 26'd1;
      end
      if (push && (!full || pop)) begin
        mem[wp[AW-1:0]] <= push_val;
        wp <= wp + 1'b1;
      end else if (push) dropped <= 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_click_decoder.sv
// tb_multi_click_decoder: randomized and directed stimulus checked against an event-level reference model
module tb_multi_click_decoder;
  localparam int W = 8;
  localparam int MAXC = 3;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, press = 0, event_ready = 0;
  logic event_valid, dropped;
  logic [3:0] event_count;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int grp = 0, last = 0;
  int q[$];
  bit drp = 0;
  multi_click_decoder #(.CLK_FREQUENCY(16), .WINDOW_HZ(2), .MAX_CLICKS(MAXC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .press(press), .event_valid(event_valid),
    .event_ready(event_ready), .event_count(event_count), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit p, input bit r, input bit rs);
    bit do_pop;
    int em;
    press = p;
    event_ready = r;
    reset = rs;
    if (rs) begin
      grp = 0;
      q.delete();
      drp = 0;
    end else begin
      do_pop = q.size() > 0 && r;
      em = 0;
      if (p) begin
        grp++;
        last = cyc;
        if (grp == MAXC) begin
          em = grp;
          grp = 0;
        end
      end else if (grp > 0 && cyc - last == W) begin
        em = grp;
        grp = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (em > 0) begin
        if (q.size() < DEPTH) q.push_back(em);
        else drp = 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("valid", int'(event_valid), int'(q.size() > 0));
    check("count", int'(event_count), q.size() > 0 ? q[0] : 0);
    check("dropped", int'(dropped), int'(drp));
  endtask
  task automatic run_pat(input logic [63:0] pat, input int len, input bit r);
    for (int i = 0; i < len; i++) step(pat[i], r, 1'b0);
  endtask
  initial begin
    @(negedge clk);
    step(0, 1, 1);
    step(0, 1, 1);
    run_pat(64'h1, 20, 1);
    run_pat(64'h21, 24, 1);
    run_pat(64'h55, 24, 1);
    run_pat(64'h101, 28, 1);
    run_pat(64'h201, 28, 1);
    run_pat(64'h0000_0100_0010_0001, 60, 0);
    run_pat(64'h0, 10, 1);
    run_pat(64'h1, 12, 1);
    run_pat(64'h9, 5, 1);
    step(0, 1, 1);
    run_pat(64'h0, 26, 1);
    run_pat(64'h1, 20, 1);
    for (int i = 0; i < 3000; i++) begin
      int pp = (i / 500) % 3 == 0 ? 4 : (i / 500) % 3 == 1 ? 12 : 40;
      step($urandom_range(pp - 1) == 0, $urandom_range(9) < 6, $urandom_range(599) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
